// File: rtl/cpu_pkg.sv
// Shared core types and constants used by the instruction fetch unit.
package cpu_pkg;
   localparam int XLEN   = 32;
   localparam int INST_W = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_REQ,
      FS_WAIT
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fq_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch unit bus: imem request/response, decode-side queue head, execute redirect.
interface fetch_ctrl_if;
   import cpu_pkg::*;

   logic              imem_req_valid;
   logic [XLEN-1:0]   imem_req_addr;
   logic              imem_req_ready;
   logic              imem_rsp_valid;
   logic [INST_W-1:0] imem_rsp_data;
   logic              inst_valid;
   logic [INST_W-1:0] inst_data;
   logic [XLEN-1:0]   inst_pc;
   logic              inst_ready;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_valid, inst_data, inst_pc,
      input  inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_valid, inst_data, inst_pc,
      output inst_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO of {pc, inst}; head always sits in entry 0.
module fetch_queue
   import cpu_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      push_i,
   input  fq_entry_t push_entry_i,
   input  logic      pop_i,
   input  logic      flush_i,
   output logic [1:0] count_o,
   output fq_entry_t head_o
);

   fq_entry_t  ent_q [2];
   logic [1:0] count_q;
   logic       pop_eff;
   logic       push_eff;
   logic [1:0] wr_idx;

   assign pop_eff  = pop_i && (count_q != 2'd0);
   assign wr_idx   = count_q - {1'b0, pop_eff};
   assign push_eff = push_i && (wr_idx != 2'd2);

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= 2'd0;
         ent_q[0] <= '0;
         ent_q[1] <= '0;
      end else if (flush_i) begin
         count_q <= 2'd0;
      end else begin
         // Shift on pop; a same-cycle push lands after the shift.
         if (pop_eff) ent_q[0] <= ent_q[1];
         if (push_eff) ent_q[wr_idx[0]] <= push_entry_i;
         count_q <= count_q + {1'b0, push_eff} - {1'b0, pop_eff};
      end
   end

   assign count_o = count_q;
   assign head_o  = ent_q[0];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the pc, issues one imem request at a time, queues words for decode.
//   state   | meaning
//   FS_IDLE | no request in flight; waits for queue space (or a stale response after reset)
//   FS_REQ  | imem_req_valid high at pc, waiting for imem_req_ready
//   FS_WAIT | one request outstanding, waiting for imem_rsp_valid
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC,
   parameter int              BUF_DEPTH = 2
) (
   input logic           clk,
   input logic           reset,
   fetch_ctrl_if.master  bus
);

   fetch_state_e    state_q;
   logic            req_valid_q;
   logic            drop_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] fa_q;

   logic [1:0]      count;
   fq_entry_t       head;
   fq_entry_t       rsp_entry;
   logic            req_fire;
   logic            pop;
   logic            push;
   logic [2:0]      count_d;
   logic            space;
   logic            drop_keep;
   logic            drop_rst;
   logic [XLEN-1:0] redir_tgt;

   assign req_fire  = req_valid_q && bus.imem_req_ready;
   assign pop       = (count != 2'd0) && bus.inst_ready;
   assign push      = (state_q == FS_WAIT) && bus.imem_rsp_valid && !drop_q && !bus.redirect_valid;
   assign count_d   = {1'b0, count} + {2'b0, push} - {2'b0, pop};
   assign space     = count_d < 3'(BUF_DEPTH);
   // A request is still owed a response if one is pending and not arriving now, or one is accepted now.
   assign drop_keep = ((state_q == FS_WAIT || drop_q) && !bus.imem_rsp_valid) || req_fire;
   assign drop_rst  = ((state_q == FS_WAIT) && !bus.imem_rsp_valid) || req_fire;
   assign redir_tgt = bus.redirect_pc & ~32'h3;
   assign rsp_entry = '{pc: fa_q, inst: bus.imem_rsp_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FS_IDLE;
         req_valid_q <= 1'b0;
         pc_q        <= RESET_PC;
         fa_q        <= RESET_PC;
         drop_q      <= drop_rst;
      end else if (bus.redirect_valid) begin
         pc_q        <= redir_tgt;
         drop_q      <= drop_keep;
         state_q     <= drop_keep ? FS_WAIT : FS_REQ;
         req_valid_q <= !drop_keep;
      end else begin
         case (state_q)
            FS_IDLE: begin
               if (drop_q) begin
                  // Stale response from before reset must drain before the next request.
                  if (bus.imem_rsp_valid) begin
                     drop_q      <= 1'b0;
                     state_q     <= space ? FS_REQ : FS_IDLE;
                     req_valid_q <= space;
                  end else begin
                     state_q <= FS_WAIT;
                  end
               end else if (space) begin
                  state_q     <= FS_REQ;
                  req_valid_q <= 1'b1;
               end
            end
            FS_REQ: begin
               if (bus.imem_req_ready) begin
                  state_q     <= FS_WAIT;
                  req_valid_q <= 1'b0;
                  fa_q        <= pc_q;
                  pc_q        <= pc_q + 32'd4;
               end
            end
            FS_WAIT: begin
               if (bus.imem_rsp_valid) begin
                  drop_q      <= 1'b0;
                  state_q     <= space ? FS_REQ : FS_IDLE;
                  req_valid_q <= space;
               end
            end
            default: begin
               state_q     <= FS_IDLE;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   fetch_queue u_queue (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .push_entry_i (rsp_entry),
      .pop_i        (pop),
      .flush_i      (bus.redirect_valid),
      .count_o      (count),
      .head_o       (head)
   );

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = (count != 2'd0);
   assign bus.inst_data      = head.inst;
   assign bus.inst_pc        = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: randomized memory/decode/redirect traffic against a queue-level model.
module tb_fetch_ctrl;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if bus ();
   fetch_ctrl_if bus2 ();

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.master)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] mq[$];
   logic [31:0] req_exp = 32'h0;
   bit          mon_en = 1'b0;
   int          cyc = 0;
   int          hs_total = 0;
   bit          mon_hs = 1'b0;
   logic [31:0] mon_hs_addr = 32'h0;

   int          p_ready = 100, p_dec = 100, p_redir = 0, p_rst = 0;
   int          lat_min = 1, lat_max = 1;
   int          o_ready = -1;
   bit          o_redir = 1'b0;
   logic [31:0] o_redir_pc = 32'h0;
   bit          o_rst = 1'b0;
   int          since_rst = 0;

   task automatic cycle();
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = word_of(pend[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
      bus.imem_req_ready = (o_ready >= 0) ? o_ready[0] : ($urandom_range(99) < p_ready);
      bus.inst_ready     = ($urandom_range(99) < p_dec);
      if (o_redir) begin
         bus.redirect_valid = 1'b1;
         bus.redirect_pc    = o_redir_pc;
         o_redir            = 1'b0;
      end else begin
         bus.redirect_valid = ($urandom_range(999) < p_redir);
         bus.redirect_pc    = $urandom;
      end
      reset  = o_rst || (since_rst > 20 && $urandom_range(999) < p_rst);
      o_rst  = 1'b0;
      since_rst = reset ? 0 : since_rst + 1;
   endtask

   // Model: pending memory responses and the decode-visible queue of fetch addresses.
   always @(negedge clk) begin
      bit hs, rsp, pop, rd;
      if (mon_en) begin
         chk("inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("inst_pc", bus.inst_pc, mq[0]);
            chk("inst_data", bus.inst_data, word_of(mq[0]));
         end
         if (mq.size() >= 2) chk("req_blocked_full", 32'(bus.imem_req_valid), 32'h0);
         hs  = bus.imem_req_valid && bus.imem_req_ready;
         rsp = bus.imem_rsp_valid;
         pop = bus.inst_valid && bus.inst_ready;
         rd  = bus.redirect_valid;
         mon_hs      = hs;
         mon_hs_addr = bus.imem_req_addr;
         if (hs) begin
            hs_total++;
            chk("one_outstanding", pend.size(), 0);
            if (!reset) begin
               chk("req_addr", bus.imem_req_addr, req_exp);
               req_exp += 32'd4;
            end
         end
         if (pop && mq.size() > 0) mq.pop_front();
         if (rsp && pend.size() > 0) begin
            if (!pend[0].stale && !reset && !rd) mq.push_back(pend[0].addr);
            pend.pop_front();
         end
         if (hs) pend.push_back('{addr: bus.imem_req_addr,
                                  due: cyc + int'($urandom_range(lat_max, lat_min)),
                                  stale: reset || rd});
         if (reset || rd) begin
            mq.delete();
            req_exp = reset ? 32'h0 : (bus.redirect_pc & ~32'h3);
            foreach (pend[i]) pend[i].stale = 1'b1;
         end
      end
   end

   // Second instance: always-ready memory and decode, records its first three requests.
   logic [31:0] w_addrs[$];
   bit          w_due = 1'b0;
   logic [31:0] w_addr = 32'h0;

   always @(negedge clk) begin
      w_due  = (bus2.imem_req_valid === 1'b1);
      w_addr = bus2.imem_req_addr;
      if (mon_en && w_due && !reset && w_addrs.size() < 3) w_addrs.push_back(w_addr);
   end

   always @(posedge clk) begin
      #1;
      bus2.imem_rsp_valid = w_due;
      bus2.imem_rsp_data  = w_addr;
   end

   task automatic wait_hs(input string tag, output logic [31:0] a, output bit ok);
      ok = 1'b0;
      a  = 32'h0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         @(negedge clk);
         #1;
         if (mon_hs) begin
            a  = mon_hs_addr;
            ok = 1'b1;
            return;
         end
      end
      chk({tag, "_timeout"}, 32'h0, 32'h1);
   endtask

   initial begin
      logic [31:0] a;
      bit          ok;
      int          h0;

      bus.imem_req_ready  = 1'b0;
      bus.imem_rsp_valid  = 1'b0;
      bus.imem_rsp_data   = 32'h0;
      bus.inst_ready      = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      bus2.imem_req_ready = 1'b1;
      bus2.imem_rsp_valid = 1'b0;
      bus2.imem_rsp_data  = 32'h0;
      bus2.inst_ready     = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc    = 32'h0;

      o_rst = 1'b1; cycle();
      mon_en = 1'b1;
      o_rst = 1'b1; cycle();
      o_rst = 1'b1; cycle();
      @(negedge clk);
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
      chk("rst_inst_data", bus.inst_data, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);

      // Streaming from reset: request in cycle 2, decode sees the word in cycle 4.
      cycle(); @(negedge clk);
      chk("first_req_c1", 32'(bus.imem_req_valid), 32'h0);
      cycle(); @(negedge clk);
      chk("first_req_c2", 32'(bus.imem_req_valid), 32'h1);
      chk("first_req_addr", bus.imem_req_addr, 32'h0);
      cycle(); @(negedge clk);
      chk("first_inst_c3", 32'(bus.inst_valid), 32'h0);
      cycle(); @(negedge clk);
      chk("first_inst_c4", 32'(bus.inst_valid), 32'h1);
      chk("first_inst_pc", bus.inst_pc, 32'h0);
      repeat (20) cycle();

      // Backpressure: decode stalls, queue fills with exactly two words.
      p_dec = 0;
      o_redir = 1'b1; o_redir_pc = 32'h40;
      cycle(); @(negedge clk); #1;
      h0 = hs_total;
      repeat (12) cycle();
      @(negedge clk); #1;
      chk("bp_req_count", hs_total - h0, 2);
      chk("bp_head_pc", bus.inst_pc, 32'h40);
      p_dec = 100;
      repeat (10) cycle();

      // Redirect while the response for 0x8 is outstanding.
      lat_min = 3; lat_max = 3;
      o_redir = 1'b1; o_redir_pc = 32'h0;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         cycle(); @(negedge clk); #1;
         if (mon_hs && mon_hs_addr == 32'h8) ok = 1'b1;
      end
      chk("saw_req_0x8", 32'(ok), 32'h1);
      o_redir = 1'b1; o_redir_pc = 32'h100;
      cycle();
      wait_hs("redir_wait_req", a, ok);
      if (ok) chk("redir_wait_req", a, 32'h100);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         cycle(); @(negedge clk); #1;
         if (bus.inst_valid) ok = 1'b1;
      end
      chk("redir_wait_valid", 32'(ok), 32'h1);
      if (ok) chk("redir_wait_inst_pc", bus.inst_pc, 32'h100);

      // Redirect coincident with the request handshake.
      lat_min = 2; lat_max = 2;
      o_ready = 0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         cycle(); @(negedge clk); #1;
         if (bus.imem_req_valid) ok = 1'b1;
      end
      chk("coinc_hs_reqvalid", 32'(ok), 32'h1);
      o_ready = 1; o_redir = 1'b1; o_redir_pc = 32'h203;
      cycle(); @(negedge clk); #1;
      chk("coinc_hs_fire", 32'(mon_hs), 32'h1);
      o_ready = -1;
      wait_hs("coinc_hs_next", a, ok);
      if (ok) chk("coinc_hs_next", a, 32'h200);

      // Redirect coincident with the response.
      wait_hs("coinc_rsp_pre", a, ok);
      cycle();
      o_redir = 1'b1; o_redir_pc = 32'h203;
      cycle();
      wait_hs("coinc_rsp_next", a, ok);
      if (ok) chk("coinc_rsp_next", a, 32'h200);

      // Reset during WAIT; the stale response lands two cycles after reset.
      lat_min = 3; lat_max = 3;
      wait_hs("rst_wait_pre", a, ok);
      o_rst = 1'b1;
      cycle();
      wait_hs("rst_restart", a, ok);
      if (ok) chk("rst_restart", a, 32'h0);
      repeat (10) cycle();

      // Randomized traffic.
      p_ready = 70; p_dec = 60; p_redir = 30; p_rst = 2;
      lat_min = 1; lat_max = 3;
      repeat (3000) cycle();
      p_redir = 0; p_rst = 0; p_dec = 100; p_ready = 100;
      repeat (20) cycle();
      @(negedge clk);

      chk("wrap_count", w_addrs.size(), 3);
      if (w_addrs.size() == 3) begin
         chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
         chk("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
         chk("wrap_addr2", w_addrs[2], 32'h0000_0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
